regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
Parametrised successor to the 64x16 datapath register file.
- Generic width and depth; two asynchronous read ports and one synchronous write port.
- Optional hardwired-zero register 0.
- Dedicated PC register with hold/increment/load modes.
- Sequencer that sweeps every register to zero after reset or on request, instead of relying on simulation init.
- Sits between decode and ALU in the single-cycle datapath; PCNext feeds instruction fetch.

Parameters:
DATA_W, 16, data width of each register
ADDR_W, 6, address width; depth = 2**ADDR_W registers
PC_W, 16, PC register width
ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes; when 0 it is ordinary storage

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
write  in  1  write enable for wrAddr/wrData
wrAddr  in  ADDR_W  write address
wrData  in  DATA_W  write data
rdAddr0  in  ADDR_W  read port 0 address
rdAddr1  in  ADDR_W  read port 1 address
rdData0  out  DATA_W  read port 0 data (combinational)
rdData1  out  DATA_W  read port 1 data (combinational)
pcMode  in  2  00 hold, 01 increment, 10 load PCAddr, 11 hold (reserved)
PCAddr  in  PC_W  PC load value
PCNext  out  PC_W  current PC register value
clrReq  in  1  single-cycle request to start a clear sweep
busy  out  1  high while the clear sweep is running

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values, after the rst edge:
  - PCNext = 0, busy = 1, rdData0 = rdData1 = 0.
  - FSM = CLEAR, sweep counter = 0.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clrReq = 1 (or on rst).
  - In CLEAR, each cycle writes 0 to reg[cnt] and increments cnt.
  - CLEAR -> IDLE on the edge that clears reg[2**ADDR_W-1]. Sweep takes exactly 2**ADDR_W cycles (64 at defaults).
  - busy = 1 exactly while the FSM is in CLEAR.
- rst asserted mid-sweep restarts the sweep at cnt = 0.
- clrReq while busy is ignored; no queueing.
- Writes:
  - reg[wrAddr] <= wrData on the rising edge when write = 1, busy = 0 and not (ZERO_REG = 1 and wrAddr = 0).
  - Writes while busy are dropped.
  - Write and clrReq in the same IDLE cycle: the write is dropped; the clear wins.
- Reads:
  - rdDataN = reg[rdAddrN], combinational.
  - Forced to 0 while busy.
  - Forced to 0 for address 0 when ZERO_REG = 1.
  - Both ports may read the same address simultaneously.
- PC:
  - Updates on every edge per pcMode, independent of busy.
  - rst has priority and forces 0.
  - Increment is modulo 2**PC_W (all-ones wraps to 0).
  - Load takes PCAddr, truncated or zero-extended to PC_W.
  - clrReq does not affect the PC.
- Read-during-write to the same address with no bypass: the read returns the old value until the edge, the new value after it.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: when write = 1, busy = 0, the write is not suppressed by ZERO_REG, and rdAddrN == wrAddr, rdDataN = wrData combinationally in the same cycle (write-first forwarding).
- Undefined: no forwarding; the read returns the stored (old) value until the write edge.
- Zero-forcing while busy applies in both builds.

Test Plan:
- Reset sweep: rst high 1 cycle, then idle.
  -> busy = 1 for exactly 64 cycles, then 0.
  -> reading any address afterwards returns 0.
  -> PCNext = 0.
- Write/read: write 17 to addr 1..4 on successive cycles, rdAddr0 = rdAddr1 = same address.
  -> both ports show 17 the cycle after each write.
  -> without the macro, 0 during the write cycle; with REGFILE_BYPASS_EN, 17 during the write cycle.
- Zero register: write 0xBEEF to addr 0 with ZERO_REG = 1.
  -> reads 0.
  -> with ZERO_REG = 0 the same write reads 0xBEEF.
- PC modes: load 0xFFFE, increment twice, hold 3 cycles.
  -> PCNext = 0xFFFE, 0xFFFF, 0x0000, 0x0000 ...
- clrReq mid-operation: fill addr 5 = 0x1234, pulse clrReq with write = 1 to addr 6.
  -> addr 6 not written; busy for 64 cycles; addr 5 reads 0 after.
  -> a second clrReq at sweep cycle 10 is ignored (busy still falls at 64).
- rst at sweep cycle 30: assert rst.
  -> counter restarts; busy stays high 64 more cycles; PCNext forced to 0 that edge.

Source files
------------

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised 2R/1W register file with PC register and clear sweep
// Optional build macro: REGFILE_BYPASS_EN (write-first forwarding onto the read ports).
module regfile_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 6,
    parameter int PC_W     = 16,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rdAddr0,
    input  logic [ADDR_W-1:0] rdAddr1,
    output logic [DATA_W-1:0] rdData0,
    output logic [DATA_W-1:0] rdData1,
    input  logic [1:0]        pcMode,
    input  logic [PC_W-1:0]   PCAddr,
    output logic [PC_W-1:0]   PCNext,
    input  logic              clrReq,
    output logic              busy
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pc_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_ok;
    logic              hit0;
    logic              hit1;

    assign wr_ok = write && !busy_q && !((ZERO_REG != 0) && (wrAddr == '0));

    // Sweep FSM also owns the storage so the clear and the user write never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    mem_q[cnt_q] <= '0;
                    cnt_q        <= cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (cnt_q == {ADDR_W{1'b1}}) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    if (clrReq) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else if (wr_ok) begin
                        mem_q[wrAddr] <= wrData;
                    end
                end
            endcase
        end
    end

    always_comb begin
        pc_d = pc_q;
        case (pcMode)
            2'b01:   pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
            2'b10:   pc_d = PCAddr;
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign hit0 = wr_ok && (rdAddr0 == wrAddr);
    assign hit1 = wr_ok && (rdAddr1 == wrAddr);
`else
    assign hit0 = 1'b0;
    assign hit1 = 1'b0;
`endif

    // Zero-forcing is applied last so it overrides both storage and forwarding.
    always_comb begin
        rdData0 = mem_q[rdAddr0];
        if (hit0) begin
            rdData0 = wrData;
        end
        if (busy_q || ((ZERO_REG != 0) && (rdAddr0 == '0))) begin
            rdData0 = '0;
        end
    end

    always_comb begin
        rdData1 = mem_q[rdAddr1];
        if (hit1) begin
            rdData1 = wrData;
        end
        if (busy_q || ((ZERO_REG != 0) && (rdAddr1 == '0))) begin
            rdData1 = '0;
        end
    end

    assign busy   = busy_q;
    assign PCNext = pc_q;
endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - randomized and directed bench for regfile_param against a behavioural model
module tb_regfile_param;
    logic        clk = 1'b0;
    logic        rst, write, clrReq;
    logic [5:0]  wrAddr, rdAddr0, rdAddr1;
    logic [15:0] wrData, PCAddr;
    logic [1:0]  pcMode;
    logic [15:0] rd0_z, rd1_z, pc_z, rd0_n, rd1_n, pc_n;
    logic        busy_z, busy_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_param #(.DATA_W(16), .ADDR_W(6), .PC_W(16), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .rdAddr0(rdAddr0), .rdAddr1(rdAddr1), .rdData0(rd0_z), .rdData1(rd1_z),
        .pcMode(pcMode), .PCAddr(PCAddr), .PCNext(pc_z), .clrReq(clrReq), .busy(busy_z)
    );

    regfile_param #(.DATA_W(16), .ADDR_W(6), .PC_W(16), .ZERO_REG(0)) dut_nz (
        .clk(clk), .rst(rst), .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .rdAddr0(rdAddr0), .rdAddr1(rdAddr1), .rdData0(rd0_n), .rdData1(rd1_n),
        .pcMode(pcMode), .PCAddr(PCAddr), .PCNext(pc_n), .clrReq(clrReq), .busy(busy_n)
    );

    // Model: a clear empties every register at once and blocks the file for 64 cycles;
    // reads are masked while blocked, so this is equivalent to a progressive sweep.
    logic [15:0] mm [64];
    int          busy_left = 0;
    logic [15:0] mpc = '0;
    bit          started = 0;

    always @(posedge clk) begin
        if (rst) begin
            started   = 1;
            busy_left = 64;
            mpc       = '0;
            for (int i = 0; i < 64; i++) mm[i] = '0;
        end else begin
            if (pcMode == 2'b01) mpc = mpc + 16'd1;
            else if (pcMode == 2'b10) mpc = PCAddr;
            if (busy_left > 0) begin
                busy_left = busy_left - 1;
            end else if (clrReq) begin
                busy_left = 64;
                for (int i = 0; i < 64; i++) mm[i] = '0;
            end else if (write) begin
                mm[wrAddr] = wrData;
            end
        end
    end

    function automatic logic [15:0] exp_rd(input logic [5:0] a, input bit zr);
        bit fwd;
        if (busy_left > 0) return 16'h0;
        if (zr && a == 6'd0) return 16'h0;
`ifdef REGFILE_BYPASS_EN
        fwd = write && !(zr && wrAddr == 6'd0) && (a == wrAddr);
`else
        fwd = 0;
`endif
        if (fwd) return wrData;
        return mm[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("busy_z", {31'd0, busy_z}, {31'd0, busy_left > 0});
            chk("busy_nz", {31'd0, busy_n}, {31'd0, busy_left > 0});
            chk("pc_z", {16'd0, pc_z}, {16'd0, mpc});
            chk("pc_nz", {16'd0, pc_n}, {16'd0, mpc});
            chk("rd0_z", {16'd0, rd0_z}, {16'd0, exp_rd(rdAddr0, 1)});
            chk("rd1_z", {16'd0, rd1_z}, {16'd0, exp_rd(rdAddr1, 1)});
            chk("rd0_nz", {16'd0, rd0_n}, {16'd0, exp_rd(rdAddr0, 0)});
            chk("rd1_nz", {16'd0, rd1_n}, {16'd0, exp_rd(rdAddr1, 0)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(input int pulse_at, output int n);
        n = 0;
        while (busy_z && n < 200) begin
            clrReq = (n == pulse_at);
            step();
            n++;
        end
        clrReq = 0;
    endtask

    int n;
    logic [15:0] during;

    initial begin
        rst = 1; write = 0; clrReq = 0; wrAddr = '0; wrData = '0;
        rdAddr0 = 6'd3; rdAddr1 = 6'd9; pcMode = 2'b00; PCAddr = '0;
        step();
        rst = 0;
        chk("reset_pc", {16'd0, pc_z}, 32'd0);
        chk("reset_busy", {31'd0, busy_z}, 32'd1);
        chk("reset_rd0", {16'd0, rd0_z}, 32'd0);
        count_busy(-1, n);
        chk("reset_sweep_len", n, 32'd64);

        for (int a = 1; a <= 4; a++) begin
            write = 1; wrAddr = 6'(a); wrData = 16'd17; rdAddr0 = 6'(a); rdAddr1 = 6'(a);
            #1;
`ifdef REGFILE_BYPASS_EN
            during = 16'd17;
`else
            during = 16'd0;
`endif
            chk("wr_during_rd0", {16'd0, rd0_z}, {16'd0, during});
            step();
            write = 0;
            #1;
            chk("wr_after_rd0", {16'd0, rd0_z}, 32'd17);
            chk("wr_after_rd1", {16'd0, rd1_z}, 32'd17);
        end

        write = 1; wrAddr = 6'd0; wrData = 16'hBEEF;
        step();
        write = 0; rdAddr0 = 6'd0; #1;
        chk("zero_reg_on", {16'd0, rd0_z}, 32'd0);
        chk("zero_reg_off", {16'd0, rd0_n}, 32'h0000BEEF);

        pcMode = 2'b10; PCAddr = 16'hFFFE; step();
        chk("pc_load", {16'd0, pc_z}, 32'h0000FFFE);
        pcMode = 2'b01; step();
        chk("pc_inc1", {16'd0, pc_z}, 32'h0000FFFF);
        step();
        chk("pc_wrap", {16'd0, pc_z}, 32'h00000000);
        pcMode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pc_hold", {16'd0, pc_z}, 32'h00000000);
        end

        write = 1; wrAddr = 6'd5; wrData = 16'h1234; step();
        write = 0; rdAddr0 = 6'd5; #1;
        chk("fill5", {16'd0, rd0_z}, 32'h00001234);
        write = 1; wrAddr = 6'd6; wrData = 16'h5555; clrReq = 1; step();
        write = 0; clrReq = 0;
        count_busy(10, n);
        chk("clr_sweep_len", n, 32'd64);
        rdAddr0 = 6'd5; rdAddr1 = 6'd6; #1;
        chk("clr_addr5", {16'd0, rd0_z}, 32'd0);
        chk("clr_addr6", {16'd0, rd1_z}, 32'd0);

        pcMode = 2'b01; clrReq = 1; step();
        clrReq = 0;
        for (int i = 0; i < 30; i++) step();
        rst = 1; step();
        rst = 0; pcMode = 2'b00;
        chk("rst_mid_pc", {16'd0, pc_z}, 32'd0);
        count_busy(-1, n);
        chk("rst_mid_len", n, 32'd64);

        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 299) == 0);
            clrReq  = ($urandom_range(0, 99) == 0);
            write   = $urandom_range(0, 1);
            wrAddr  = $urandom_range(0, 1) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            rdAddr0 = $urandom_range(0, 1) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            rdAddr1 = $urandom_range(0, 1) ? wrAddr : 6'($urandom_range(0, 63));
            wrData  = 16'($urandom);
            pcMode  = 2'($urandom_range(0, 3));
            PCAddr  = 16'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
